// File: rtl/crossbar_slave_arbiter.sv
// Per-slave-port round-robin arbiter and transaction sequencer
// for the 2x2 crossbar, with ack timeout recovery.
module crossbar_slave_arbiter #(
  parameter int          SLAVE_ID = 0,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] TO_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        master_0_req,
  input  logic        master_0_cmd,
  input  logic [31:0] master_0_addr,
  input  logic [31:0] master_0_wdata,
  output logic [31:0] master_0_rdata,
  output logic        master_0_ack,
  input  logic        master_1_req,
  input  logic        master_1_cmd,
  input  logic [31:0] master_1_addr,
  input  logic [31:0] master_1_wdata,
  output logic [31:0] master_1_rdata,
  output logic        master_1_ack,
  output logic        slave_req,
  output logic        slave_cmd,
  output logic [31:0] slave_addr,
  output logic [31:0] slave_wdata,
  input  logic [31:0] slave_rdata,
  input  logic        slave_ack,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic SID = (SLAVE_ID != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic elig0, elig1, pick1;
  logic busy, acking, sel1;

  assign elig0 = master_0_req & (master_0_addr[31] == SID);
  assign elig1 = master_1_req & (master_1_addr[31] == SID);
  // last_q holds the index of the previous winner; the other one wins ties
  assign pick1 = elig1 & (~elig0 | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (slave_ack) begin
          rdata_d = slave_rdata;
          state_d = ACK;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          rdata_d = TO_RDATA;
          terr_d  = 1'b1;
          state_d = ACK;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: begin
        if (slave_ack) begin
          state_d = RELEASE;
        end else begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      RELEASE: begin
        // a lingering ack must not complete the next transaction
        if (!slave_ack) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      rdata_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign acking = (state_q == ACK);
  assign sel1   = grant_q[1];

  assign slave_req   = busy;
  assign slave_cmd   = busy & (sel1 ? master_1_cmd : master_0_cmd);
  assign slave_addr  = busy ? (sel1 ? master_1_addr : master_0_addr)
                            : 32'h0;
  assign slave_wdata = busy ? (sel1 ? master_1_wdata : master_0_wdata)
                            : 32'h0;

  assign master_0_ack   = acking & grant_q[0];
  assign master_1_ack   = acking & grant_q[1];
  assign master_0_rdata = master_0_ack ? rdata_q : 32'h0;
  assign master_1_rdata = master_1_ack ? rdata_q : 32'h0;

  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Bench for crossbar_slave_arbiter: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_crossbar_slave_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_cmd, m1_req, m1_cmd;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        s_req, s_cmd, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        terr;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  crossbar_slave_arbiter #(
    .SLAVE_ID(0),
    .TIMEOUT(TO),
    .TO_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_0_req(m0_req),
    .master_0_cmd(m0_cmd),
    .master_0_addr(m0_addr),
    .master_0_wdata(m0_wdata),
    .master_0_rdata(m0_rdata),
    .master_0_ack(m0_ack),
    .master_1_req(m1_req),
    .master_1_cmd(m1_cmd),
    .master_1_addr(m1_addr),
    .master_1_wdata(m1_wdata),
    .master_1_rdata(m1_rdata),
    .master_1_ack(m1_ack),
    .slave_req(s_req),
    .slave_cmd(s_cmd),
    .slave_addr(s_addr),
    .slave_wdata(s_wdata),
    .slave_rdata(s_rdata),
    .slave_ack(s_ack),
    .grant(grant),
    .timeout_err(terr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the slave, which phase of the
  // transaction it is in, and what the owner will be handed back.
  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_ACK  = 2;
  localparam int PH_REL  = 3;

  int          md_own;
  int          md_ph;
  int          md_wait;
  int          md_last;
  logic [31:0] md_rd;
  logic        md_terr;

  function automatic int pick(input bit e0, input bit e1,
                              input int last);
    if (e0 && e1) return 1 - last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic int winner();
    return pick(m0_req && (m0_addr[31] == 1'b0),
                m1_req && (m1_addr[31] == 1'b0), md_last);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_own  <= -1;
      md_ph   <= PH_IDLE;
      md_wait <= 0;
      md_last <= 1;
      md_rd   <= 32'h0;
      md_terr <= 1'b0;
    end else begin
      case (md_ph)
        PH_IDLE: begin
          if (winner() >= 0) begin
            md_own  <= winner();
            md_last <= winner();
            md_wait <= 0;
            md_ph   <= PH_BUSY;
          end
        end
        PH_BUSY: begin
          if (s_ack) begin
            md_rd <= s_rdata;
            md_ph <= PH_ACK;
          end else if (md_wait + 1 >= TO) begin
            md_rd   <= 32'hDEAD_BEEF;
            md_terr <= 1'b1;
            md_ph   <= PH_ACK;
          end else begin
            md_wait <= md_wait + 1;
          end
        end
        PH_ACK: begin
          if (s_ack) begin
            md_ph <= PH_REL;
          end else begin
            md_ph  <= PH_IDLE;
            md_own <= -1;
          end
        end
        default: begin
          if (!s_ack) begin
            md_ph  <= PH_IDLE;
            md_own <= -1;
          end
        end
      endcase
    end
  end

  function automatic logic [1:0] e_grant();
    if (md_own == 0) return 2'b01;
    if (md_own == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic e_busy();
    return md_ph == PH_BUSY;
  endfunction

  function automatic logic e_ack(input int m);
    return (md_ph == PH_ACK) && (md_own == m);
  endfunction

  function automatic logic [31:0] e_field(input int f);
    if (!e_busy()) return 32'h0;
    case (f)
      0: return 32'(md_own == 1 ? m1_cmd : m0_cmd);
      1: return md_own == 1 ? m1_addr : m0_addr;
      default: return md_own == 1 ? m1_wdata : m0_wdata;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_grant", 32'(grant), 32'(e_grant()));
      chk("m_slave_req", 32'(s_req), 32'(e_busy()));
      chk("m_slave_cmd", 32'(s_cmd), e_field(0));
      chk("m_slave_addr", s_addr, e_field(1));
      chk("m_slave_wdata", s_wdata, e_field(2));
      chk("m_ack0", 32'(m0_ack), 32'(e_ack(0)));
      chk("m_ack1", 32'(m1_ack), 32'(e_ack(1)));
      chk("m_rdata0", m0_rdata, e_ack(0) ? md_rd : 32'h0);
      chk("m_rdata1", m1_rdata, e_ack(1) ? md_rd : 32'h0);
      chk("m_timeout_err", 32'(terr), 32'(md_terr));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m(input logic ack, inout logic req,
                         inout logic cmd, inout logic [31:0] addr,
                         inout logic [31:0] wdata);
    if (req && ack) begin
      if ($urandom_range(0, 9) < 8) req = 1'b0;
    end else if (!req) begin
      if ($urandom_range(0, 9) < 3) begin
        req   = 1'b1;
        cmd   = 1'($urandom_range(0, 1));
        addr  = $urandom;
        addr[31] = ($urandom_range(0, 7) == 0);
        wdata = $urandom;
      end
    end else if (addr[31] && $urandom_range(0, 9) < 2) begin
      req = 1'b0;
    end else if ($urandom_range(0, 99) == 0) begin
      req = 1'b0;
    end
  endtask

  int n0, n1;

  initial begin
    rst = 1'b1;
    {m0_req, m0_cmd, m1_req, m1_cmd, s_ack} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata} = '0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_slave_req", 32'(s_req), 32'h0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    chk("rst_terr", 32'(terr), 32'h0);
    rst = 1'b0;

    // m0 read then m1 write, both targeting this slave
    m0_req = 1'b1; m0_cmd = 1'b0; m0_addr = 32'h0000_0010;
    m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_cmd = 1'b1; m1_addr = 32'h0000_0020;
    m1_wdata = 32'h000f_eed1;
    tick();
    chk("t1_grant_m0", 32'(grant), 32'h1);
    chk("t1_slave_req", 32'(s_req), 32'h1);
    chk("t1_slave_addr", s_addr, 32'h0000_0010);
    s_ack = 1'b1; s_rdata = 32'hfeed_00c0;
    tick();
    chk("t1_m0_ack", 32'(m0_ack), 32'h1);
    chk("t1_m0_rdata", m0_rdata, 32'hfeed_00c0);
    chk("t1_m1_ack", 32'(m1_ack), 32'h0);
    m0_req = 1'b0; s_ack = 1'b0; s_rdata = 32'h0;
    tick();
    chk("t1_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("t1_grant_m1", 32'(grant), 32'h2);
    chk("t1_slave_cmd", 32'(s_cmd), 32'h1);
    chk("t1_slave_wdata", s_wdata, 32'h000f_eed1);
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    chk("t1_m1_ack", 32'(m1_ack), 32'h1);
    m1_req = 1'b0; s_ack = 1'b0;
    tick();

    // slave_ack lingers after completion
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("t2_grant_m0", 32'(grant), 32'h1);
    s_ack = 1'b1; s_rdata = 32'h0000_0a0a;
    tick();
    chk("t2_m0_ack", 32'(m0_ack), 32'h1);
    m0_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_rel_grant", 32'(grant), 32'h1);
      chk("t2_rel_acks", 32'({m0_ack, m1_ack}), 32'h0);
      chk("t2_rel_sreq", 32'(s_req), 32'h0);
    end
    s_ack = 1'b0;
    tick();
    chk("t2_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("t2_grant_m1", 32'(grant), 32'h2);
    s_ack = 1'b1;
    tick();
    chk("t2_m1_ack", 32'(m1_ack), 32'h1);
    m1_req = 1'b0; s_ack = 1'b0;
    tick();

    // eight back-to-back transactions alternate owners
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    n0 = 0; n1 = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("t3_grant", 32'(grant), (t % 2 == 0) ? 32'h1 : 32'h2);
      s_ack = 1'b1;
      tick();
      n0 += int'(m0_ack);
      n1 += int'(m1_ack);
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
      s_ack = 1'b0;
      tick();
      if (t < 7) begin
        m0_req = 1'b1; m1_req = 1'b1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("t3_m0_acks", 32'(n0), 32'd4);
    chk("t3_m1_acks", 32'(n1), 32'd4);

    // request aimed at the other slave
    m1_req = 1'b1; m1_addr = 32'h8000_0004;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t4_grant", 32'(grant), 32'h0);
      chk("t4_sreq", 32'(s_req), 32'h0);
    end
    m1_req = 1'b0;
    tick();

    // silent slave
    m0_req = 1'b1; m0_addr = 32'h0000_0044; m0_cmd = 1'b0;
    tick();
    chk("t5_sreq", 32'(s_req), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_wait_ack", 32'(m0_ack), 32'h0);
    end
    tick();
    chk("t5_ack", 32'(m0_ack), 32'h1);
    chk("t5_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t5_terr", 32'(terr), 32'h1);
    m0_req = 1'b0;
    tick();
    tick();
    chk("t5_terr_sticky", 32'(terr), 32'h1);
    chk("t5_grant", 32'(grant), 32'h0);

    // async reset in the middle of a transaction
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h0000_0030;
    tick();
    chk("t6_busy", 32'(s_req), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_sreq", 32'(s_req), 32'h0);
    chk("t6_rst_saddr", s_addr, 32'h0);
    chk("t6_rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    chk("t6_rst_terr", 32'(terr), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_grant_m0", 32'(grant), 32'h1);
    s_ack = 1'b1;
    tick();
    chk("t6_m0_ack", 32'(m0_ack), 32'h1);
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    tick();

    // randomized traffic, checked every cycle by the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc == 1500) rst = 1'b1;
      if (cyc == 1502) rst = 1'b0;
      drive_m(m0_ack, m0_req, m0_cmd, m0_addr, m0_wdata);
      drive_m(m1_ack, m1_req, m1_cmd, m1_addr, m1_wdata);
      if (s_ack) s_ack = ($urandom_range(0, 2) != 0);
      else if (s_req) s_ack = ($urandom_range(0, 2) == 0);
      else s_ack = ($urandom_range(0, 19) == 0);
      s_rdata = $urandom;
    end
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crossbar_slave_arbiter.md
# crossbar_slave_arbiter

Per-slave-port arbiter and transaction sequencer for the 2-master / 2-slave crossbar. One instance sits in front of each slave port. It selects which master owns the slave using round-robin fairness and holds the grant for the full request/ack transaction. It routes command, address and write data to the slave, returns read data and ack to the owning master, and recovers from a slave that never acks.

## Interface
Parameters:
- SLAVE_ID, 0: value of address bit 31 that targets this slave.
- TIMEOUT, 255: cycles in BUSY before forced completion; 0 disables the timeout.
- TO_RDATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- master_0_req / master_1_req  in  1  request, held high until that master's ack.
- master_0_cmd / master_1_cmd  in  1  0 = read, 1 = write.
- master_0_addr / master_1_addr  in  32  address; bit 31 selects the slave.
- master_0_wdata / master_1_wdata  in  32  write data.
- master_0_rdata / master_1_rdata  out  32  read data, valid while the matching ack is high.
- master_0_ack / master_1_ack  out  1  one-cycle completion pulse.
- slave_req  out  1  transaction presented to the slave.
- slave_cmd, slave_addr, slave_wdata  out  1/32/32  fields muxed from the granted master.
- slave_rdata  in  32  slave read data, sampled when slave_ack is high.
- slave_ack  in  1  slave completion; may stay high for several cycles.
- grant  out  2  one-hot owner; 00 when idle.
- timeout_err  out  1  sticky flag, cleared only by rst.

## Operation
- A master is eligible when master_N_req=1 and master_N_addr[31]==SLAVE_ID.
- Round-robin uses a last_grant register, reset to 1, so master 0 wins the first tie. When both masters are eligible, the master other than last_grant wins. When one master is eligible, it wins. last_grant updates on each grant.
- The state machine has four states: IDLE, BUSY, ACK and RELEASE.
- IDLE:
  - If any master is eligible, latch grant and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - slave_req=1.
  - slave_cmd, slave_addr and slave_wdata are combinationally muxed from the granted master.
  - On slave_ack=1: capture slave_rdata into the read-data register and go to ACK.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT−1 with no ack: load TO_RDATA into the read-data register, set timeout_err and go to ACK.
- ACK:
  - The owner's ack=1 for exactly one cycle, and its rdata equals the read-data register.
  - The non-owner's ack is 0 and its rdata is 0.
  - Next state is RELEASE if slave_ack=1, otherwise IDLE.
- RELEASE: wait for slave_ack=0, then go to IDLE. This blocks a stale ack from completing the next transaction.
- grant clears when entering IDLE.
- Timeout counter: 8-bit minimum width, sized to TIMEOUT. It clears on entering BUSY, increments each BUSY cycle and saturates; it does not wrap.
- When slave_req=0, slave outputs are 0. Write transactions still complete via slave_ack; rdata returned on a write is don't-care, but it is still driven from the read-data register.
- Reset (asserted asynchronously, including mid-transaction):
  - state = IDLE; grant = 00; last_grant = 1.
  - All ack and rdata outputs 0; slave_req, slave_cmd, slave_addr, slave_wdata 0.
  - Counter 0; timeout_err 0.
  - A transaction in flight is dropped without an ack.

## Timing
- Grant latency: eligible request sampled at edge N → slave_req=1 during cycle N+1.
- Completion: slave_ack sampled high at edge M in BUSY → master ack high for the cycle after edge M, low after edge M+1.
- Minimum transaction: 3 cycles IDLE→IDLE when slave_ack is already high at the first BUSY edge and low by the ACK edge.
- Back-to-back: after ACK→IDLE, a pending request from the other master is granted at the next edge.
  - Turnaround is 1 idle cycle.
  - The acked master must drop req by the edge ending ACK, otherwise it is re-arbitrated as a new request.
- Requests arriving during BUSY, ACK or RELEASE wait; there is no preemption.
- A master's req dropping mid-BUSY is ignored; the transaction completes.
- A simultaneous new request and completion are resolved by the state machine: new requests are only sampled in IDLE.

## Test plan
- Both masters request, both addr[31]=0, SLAVE_ID=0, m0 read, m1 write, slave_ack pulsed per transaction → m0 granted first, gets rdata=32'hfeed00c0; m1 granted next with slave_wdata=32'h000feed1 and slave_cmd=1, gets ack.
- slave_ack held high 3 cycles after completion → state sits in RELEASE, one master ack only, no second grant until slave_ack falls.
- Continuous requests from both masters for 8 transactions → grants alternate 01,10,01,…; each master acked 4 times.
- m1 request with addr[31]=1 on the SLAVE_ID=0 instance → never granted, grant stays 00, slave_req stays 0.
- TIMEOUT=4, slave never acks → m0 ack exactly 4 cycles after slave_req rises, rdata=32'hDEAD_BEEF, timeout_err=1 and sticky.
- rst asserted mid-BUSY between edges → all outputs 0 immediately; after release, pending requests re-arbitrate with m0 winning the tie.
